// File: rtl/run_detector_if.sv
// run_detector_if: symbol stream and detection result bundle for run_detector.
//   slave  : used by run_detector (consumes i_*, produces o_*)
//   master : used by the source/observer (drives i_*, observes o_*)
// Signals:
//   i_in_valid  symbol qualifier
//   i_in        WIDTH-bit symbol
//   i_overlap   0 = non-overlapping, 1 = overlapping detection
//   o_out       registered one-cycle detection pulse
//   o_out_sym   symbol of the most recent detection
//   o_det_count saturating detection count (0 when counting is not built)
interface run_detector_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic             i_in_valid;
  logic [WIDTH-1:0] i_in;
  logic             i_overlap;
  logic             o_out;
  logic [WIDTH-1:0] o_out_sym;
  logic [CNT_W-1:0] o_det_count;

  modport slave (
    input  i_in_valid, i_in, i_overlap,
    output o_out, o_out_sym, o_det_count
  );

  modport master (
    output i_in_valid, i_in, i_overlap,
    input  o_out, o_out_sym, o_det_count
  );
endinterface

// File: rtl/run_detector.sv
// run_detector: pulses o_out when RUN_LEN consecutive accepted symbols are equal.
// Gaps (i_in_valid=0) hold the run. Overlapping mode re-detects on every further
// equal symbol; non-overlapping mode restarts after each detection.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-low reset
//   bus      run_detector_if.slave (symbol stream in, detection results out)
// Optional feature: define RUN_DETECT_COUNT_EN to build the saturating
// detection counter; otherwise o_det_count is tied to 0.
module run_detector #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic          i_clock,
  input  logic          i_reset,
  run_detector_if.slave bus
);

  localparam int unsigned CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(RUN_LEN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_last_sym;
  logic [CW-1:0]    r_run_cnt;
  logic             r_out;
  logic [WIDTH-1:0] r_out_sym;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_last_sym_nxt;
  logic [CW-1:0]    w_run_cnt_nxt;
  logic             w_det;
  logic             w_eq;

  assign w_eq = (bus.i_in == r_last_sym);

  // Next-state and detection decode
  always_comb begin
    w_state_nxt    = r_state;
    w_last_sym_nxt = r_last_sym;
    w_run_cnt_nxt  = r_run_cnt;
    w_det          = 1'b0;
    if (bus.i_in_valid) begin
      case (r_state)
        IDLE: begin
          w_state_nxt    = RUN;
          w_last_sym_nxt = bus.i_in;
          w_run_cnt_nxt  = CW'(1);
        end
        RUN: begin
          if (!w_eq) begin
            w_last_sym_nxt = bus.i_in;
            w_run_cnt_nxt  = CW'(1);
          end else if (r_run_cnt < LAST_CNT) begin
            w_run_cnt_nxt = r_run_cnt + CW'(1);
          end else begin
            w_det = 1'b1;
            // Overlapping keeps run_cnt at RUN_LEN-1 so the next equal symbol detects again
            if (!bus.i_overlap) begin
              w_state_nxt   = IDLE;
              w_run_cnt_nxt = '0;
            end
          end
        end
        default: begin
          w_state_nxt   = IDLE;
          w_run_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_last_sym <= '0;
      r_run_cnt  <= '0;
      r_out      <= 1'b0;
      r_out_sym  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_sym <= w_last_sym_nxt;
      r_run_cnt  <= w_run_cnt_nxt;
      r_out      <= w_det;
      if (w_det) begin
        r_out_sym <= bus.i_in;
      end
    end
  end

  assign bus.o_out     = r_out;
  assign bus.o_out_sym = r_out_sym;

`ifdef RUN_DETECT_COUNT_EN
  logic [CNT_W-1:0] r_det_count;

  // Saturating detection counter
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_det_count <= '0;
    end else if (w_det && (r_det_count != {CNT_W{1'b1}})) begin
      r_det_count <= r_det_count + CNT_W'(1);
    end
  end

  assign bus.o_det_count = r_det_count;
`else
  assign bus.o_det_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector: directed vectors with hand-computed expectations pushed into
// per-DUT scoreboards; monitors pop and compare one cycle after each edge.
// d1: WIDTH=1 RUN_LEN=2 CNT_W=2   d3: WIDTH=4 RUN_LEN=3 CNT_W=8
module tb_run_detector;

  typedef struct packed {
    logic       o;
    logic [3:0] sym;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst1;
  logic rst3;
  int   checks;
  int   errors;

  exp_t q1[$];
  exp_t q3[$];

  run_detector_if #(.WIDTH(1), .CNT_W(2)) if1 ();
  run_detector_if #(.WIDTH(4), .CNT_W(8)) if3 ();

  run_detector #(.WIDTH(1), .RUN_LEN(2), .CNT_W(2)) d1 (
    .i_clock (clk),
    .i_reset (rst1),
    .bus     (if1.slave)
  );

  run_detector #(.WIDTH(4), .RUN_LEN(3), .CNT_W(8)) d3 (
    .i_clock (clk),
    .i_reset (rst3),
    .bus     (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value depends on whether the counter is built
  function automatic logic [7:0] cv(input int n);
`ifdef RUN_DETECT_COUNT_EN
    return 8'(n);
`else
    return 8'(n) & 8'h00;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare DUT outputs against queued expectations after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1_out", 8'(if1.o_out), 8'(e.o));
      chk("d1_sym", 8'(if1.o_out_sym), 8'(e.sym));
      chk("d1_cnt", 8'(if1.o_det_count), e.cnt);
    end
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("d3_out", 8'(if3.o_out), 8'(e.o));
      chk("d3_sym", 8'(if3.o_out_sym), 8'(e.sym));
      chk("d3_cnt", 8'(if3.o_det_count), e.cnt);
    end
  end

  // Drive one cycle on DUT d and queue the expected outputs after that edge
  task automatic step(input int d, input logic rn, input logic v, input logic [3:0] s,
                      input logic ov, input logic eo, input logic [3:0] es, input int ec);
    exp_t e;
    e.o   = eo;
    e.sym = es;
    e.cnt = cv(ec);
    if (d == 1) begin
      rst1           = rn;
      if1.i_in_valid = v;
      if1.i_in       = s[0];
      if1.i_overlap  = ov;
      q1.push_back(e);
    end else begin
      rst3           = rn;
      if3.i_in_valid = v;
      if3.i_in       = s;
      if3.i_overlap  = ov;
      q3.push_back(e);
    end
    @(posedge clk);
    #2;
    rst1           = 1'b1;
    rst3           = 1'b1;
    if1.i_in_valid = 1'b0;
    if3.i_in_valid = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst1           = 1'b0;
    rst3           = 1'b0;
    if1.i_in_valid = 1'b0;
    if1.i_in       = 1'b0;
    if1.i_overlap  = 1'b0;
    if3.i_in_valid = 1'b0;
    if3.i_in       = 4'h0;
    if3.i_overlap  = 1'b0;

    // Reset state
    step(1, 0, 0, 4'h0, 0, 0, 4'h0, 0);
    step(3, 0, 0, 4'h0, 0, 0, 4'h0, 0);

    // Non-overlapping, 1,1,1,1: pulses after 2nd and 4th
    step(1, 1, 1, 4'h1, 0, 0, 4'h0, 0);
    step(1, 1, 1, 4'h1, 0, 1, 4'h1, 1);
    step(1, 1, 1, 4'h1, 0, 0, 4'h1, 1);
    step(1, 1, 1, 4'h1, 0, 1, 4'h1, 2);
    step(1, 1, 0, 4'h1, 0, 0, 4'h1, 2);
    step(1, 0, 0, 4'h0, 0, 0, 4'h0, 0);

    // Overlapping, 1 x6: back-to-back pulses, counter saturates at 3
    step(1, 1, 1, 4'h1, 1, 0, 4'h0, 0);
    step(1, 1, 1, 4'h1, 1, 1, 4'h1, 1);
    step(1, 1, 1, 4'h1, 1, 1, 4'h1, 2);
    step(1, 1, 1, 4'h1, 1, 1, 4'h1, 3);
    step(1, 1, 1, 4'h1, 1, 1, 4'h1, 3);
    step(1, 1, 1, 4'h1, 1, 1, 4'h1, 3);
    step(1, 1, 0, 4'h1, 1, 0, 4'h1, 3);
    step(1, 0, 0, 4'h0, 0, 0, 4'h0, 0);

    // Gap holds the run: 0, three invalid cycles with toggling input, 0
    step(1, 1, 1, 4'h0, 0, 0, 4'h0, 0);
    step(1, 1, 0, 4'h1, 0, 0, 4'h0, 0);
    step(1, 1, 0, 4'h0, 0, 0, 4'h0, 0);
    step(1, 1, 0, 4'h1, 0, 0, 4'h0, 0);
    step(1, 1, 1, 4'h0, 0, 1, 4'h0, 1);
    // Unequal symbol restarts the run
    step(1, 1, 1, 4'h1, 0, 0, 4'h0, 1);
    step(1, 1, 1, 4'h0, 0, 0, 4'h0, 1);
    step(1, 1, 1, 4'h0, 0, 1, 4'h0, 2);

    // Reset mid-run discards the partial run
    step(1, 1, 1, 4'h1, 0, 0, 4'h0, 2);
    step(1, 0, 1, 4'h1, 0, 0, 4'h0, 0);
    step(1, 1, 1, 4'h1, 0, 0, 4'h0, 0);

    // Mode sampled on the detection edge: overlap=1 then overlap=0
    step(1, 1, 1, 4'h1, 1, 1, 4'h1, 1);
    step(1, 1, 1, 4'h1, 0, 1, 4'h1, 2);
    step(1, 1, 1, 4'h1, 0, 0, 4'h1, 2);

    // WIDTH=4 RUN_LEN=3: A,A,B,B,B -> single pulse, out_sym=B
    step(3, 1, 1, 4'hA, 0, 0, 4'h0, 0);
    step(3, 1, 1, 4'hA, 0, 0, 4'h0, 0);
    step(3, 1, 1, 4'hB, 0, 0, 4'h0, 0);
    step(3, 1, 1, 4'hB, 0, 0, 4'h0, 0);
    step(3, 1, 1, 4'hB, 0, 1, 4'hB, 1);
    step(3, 1, 0, 4'hB, 0, 0, 4'hB, 1);
    // Overlapping run of 3 then a different symbol
    step(3, 1, 1, 4'h5, 1, 0, 4'hB, 1);
    step(3, 1, 1, 4'h5, 1, 0, 4'hB, 1);
    step(3, 1, 1, 4'h5, 1, 1, 4'h5, 2);
    step(3, 1, 1, 4'h5, 1, 1, 4'h5, 3);
    step(3, 1, 1, 4'hC, 1, 0, 4'h5, 3);

    @(posedge clk);
    #3;
    chk("q1_drain", 8'(q1.size()), 8'd0);
    chk("q3_drain", 8'(q3.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
